// File: rtl/sipo_word_receiver_pkg.sv
// Shared types and constants for the serial-in, parallel-out word receiver.
package sipo_word_receiver_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } coll_state_e;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit position counter for the collector: counts strobes, clears on sync or wrap.
module sipo_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          strobe_i,
  input  logic          sync_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o
);

  logic [CW-1:0] count_q, count_d;

  // A strobe coinciding with sync is the first bit of a fresh word.
  always_comb begin
    count_d = count_q;
    wrap_o  = strobe_i && !sync_i && (count_q == CW'(WIDTH - 1));
    if (sync_i) begin
      count_d = strobe_i ? CW'(1) : '0;
    end else if (strobe_i) begin
      count_d = wrap_o ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sipo_word_receiver.sv
// Serial-to-parallel word receiver with a double-buffered output word,
// selectable bit order per word, frame resync and a sticky overrun flag.
// Handshake: data_out is transferred on every rising edge where out_valid && out_ready.
module sipo_word_receiver
  import sipo_word_receiver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_valid,
  input  logic             serial_in,
  input  logic             lsb_first,
  input  logic             sync,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             busy,
  output logic             dbg_state
);

  localparam int CW = $clog2(WIDTH);

  coll_state_e      state_q;
  logic [WIDTH-1:0] shift_q, shift_d, shift_base;
  logic             order_q, order_eff, first_bit;
  logic [WIDTH-1:0] data_q;
  logic             valid_q, overrun_q;
  logic [CW-1:0]    count;
  logic             wrap;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .strobe_i (ser_valid),
    .sync_i   (sync),
    .count_o  (count),
    .wrap_o   (wrap)
  );

  // Bit order is sampled with the first bit of a word and frozen until the word ends.
  always_comb begin
    first_bit  = sync || (count == '0);
    order_eff  = first_bit ? lsb_first : order_q;
    shift_base = sync ? '0 : shift_q;
    if (order_eff == LSB_FIRST) begin
      shift_d = {serial_in, shift_base[WIDTH-1:1]};
    end else begin
      shift_d = {shift_base[WIDTH-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      order_q   <= MSB_FIRST;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (ser_valid) begin
        shift_q <= wrap ? '0 : shift_d;
        if (first_bit) order_q <= lsb_first;
      end else if (sync) begin
        shift_q <= '0;
      end

      if (sync) begin
        state_q <= ser_valid ? COLLECT : IDLE;
      end else if (ser_valid) begin
        state_q <= wrap ? IDLE : COLLECT;
      end

      // A completed word may replace a word being consumed on the same edge.
      if (wrap) begin
        if (!valid_q || out_ready) begin
          data_q  <= shift_d;
          valid_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      if (wrap && valid_q && !out_ready) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == COLLECT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Directed bench for sipo_word_receiver (WIDTH = 8) with a scoreboard of accepted words.
module tb_sipo_word_receiver;

  localparam int W = 8;

  logic         clk, rst_n;
  logic         ser_valid, serial_in, lsb_first, sync, out_ready, clr_overrun;
  logic [W-1:0] data_out;
  logic         out_valid, overrun, busy, dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  sipo_word_receiver #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_valid   (ser_valid),
    .serial_in   (serial_in),
    .lsb_first   (lsb_first),
    .sync        (sync),
    .out_ready   (out_ready),
    .clr_overrun (clr_overrun),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .overrun     (overrun),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=%0h req=%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every handshake seen away from the clock edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'h0, data_out}, 32'hFFFF_FFFF);
      end else begin
        chk("word", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    serial_in = b;
    tick();
    ser_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input logic lsb, input int from, input int to);
    for (int i = from; i < to; i++) begin
      lsb_first = lsb;
      send_bit(lsb ? w[i] : w[W-1-i]);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic lsb);
    send_bits(w, lsb, 0, W);
  endtask

  initial begin
    rst_n = 1'b0; ser_valid = 1'b0; serial_in = 1'b0; lsb_first = 1'b0;
    sync = 1'b0; out_ready = 1'b1; clr_overrun = 1'b0;
    #12;
    chk("reset_data", {24'h0, data_out}, 32'h0);
    chk("reset_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // MSB-first 1,0,0,0,1,1,1,1 -> 8F, valid for exactly one cycle
    exp_q.push_back(8'h8F);
    send_bits(8'h8F, 1'b0, 0, 7);
    chk("busy_midword", {31'h0, busy}, 32'h1);
    send_bits(8'h8F, 1'b0, 7, 8);
    chk("msb_data", {24'h0, data_out}, 32'h8F);
    chk("msb_valid_set", {31'h0, out_valid}, 32'h1);
    chk("msb_busy_clear", {31'h0, busy}, 32'h0);
    tick();
    chk("msb_valid_one_cycle", {31'h0, out_valid}, 32'h0);

    // LSB-first same bits -> F1; then order toggled after bit 3 must be ignored
    exp_q.push_back(8'hF1);
    send_word(8'hF1, 1'b1);
    chk("lsb_data", {24'h0, data_out}, 32'hF1);
    tick();
    exp_q.push_back(8'hF1);
    send_bits(8'hF1, 1'b1, 0, 3);
    lsb_first = 1'b0;
    for (int i = 3; i < W; i++) send_bit((i < 4) ? 1'b0 : 1'b1);
    chk("lsb_toggle_data", {24'h0, data_out}, 32'hF1);
    tick();

    // Consumer stalled: A5 held, 3C dropped with overrun
    out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 1'b0);
    chk("ovr_before", {31'h0, overrun}, 32'h0);
    send_word(8'h3C, 1'b0);
    chk("ovr_data_held", {24'h0, data_out}, 32'hA5);
    chk("ovr_valid_held", {31'h0, out_valid}, 32'h1);
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    tick(); tick();
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_cleared", {31'h0, overrun}, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("ovr_drained", {31'h0, out_valid}, 32'h0);

    // Stray bits discarded by sync
    send_bits(8'hFF, 1'b0, 0, 3);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_busy_clear", {31'h0, busy}, 32'h0);
    chk("sync_no_valid", {31'h0, out_valid}, 32'h0);
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1'b0);
    chk("sync_data", {24'h0, data_out}, 32'h5A);
    tick();

    // Sync together with a strobe: that bit starts the new word (96 = 1001_0110)
    send_bits(8'hFF, 1'b0, 0, 2);
    exp_q.push_back(8'h96);
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    chk("sync_strobe_busy", {31'h0, busy}, 32'h1);
    send_bits(8'h96, 1'b0, 1, 8);
    chk("sync_strobe_data", {24'h0, data_out}, 32'h96);
    tick();

    // Word completes on the same edge the held word is consumed
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_word(8'h11, 1'b0);
    send_bits(8'h22, 1'b0, 0, 7);
    exp_q.push_back(8'h22);
    out_ready = 1'b1;
    send_bits(8'h22, 1'b0, 7, 8);
    chk("swap_data", {24'h0, data_out}, 32'h22);
    chk("swap_valid", {31'h0, out_valid}, 32'h1);
    chk("swap_no_overrun", {31'h0, overrun}, 32'h0);
    tick();
    chk("swap_drained", {31'h0, out_valid}, 32'h0);

    // Asynchronous reset mid-word, then a clean word
    send_bits(8'hFF, 1'b0, 0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_data", {24'h0, data_out}, 32'h0);
    chk("async_valid", {31'h0, out_valid}, 32'h0);
    chk("async_overrun", {31'h0, overrun}, 32'h0);
    chk("async_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_q.push_back(8'hC3);
    send_word(8'hC3, 1'b0);
    chk("post_reset_data", {24'h0, data_out}, 32'hC3);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
